// File: rtl/regfile_arbiter_if.sv
// regfile_arbiter_if: request/ack handshakes for the MAC and sig requesters plus the register-file port.
//   slave  : arbiter side (samples requests, drives acks and the rf_* strobes, samples rf_rdata)
//   master : requester/register-file side (drives requests and rf_rdata, samples acks and rf_* strobes)
interface regfile_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7
);
    logic              mac_req;
    logic              mac_we;
    logic [ADDR_W-1:0] mac_addr;
    logic [DATA_W-1:0] mac_wdata;
    logic              mac_ack;
    logic [DATA_W-1:0] mac_rdata;
    logic              mac_err;
    logic              sig_req;
    logic              sig_we;
    logic [ADDR_W-1:0] sig_addr;
    logic [DATA_W-1:0] sig_wdata;
    logic              sig_ack;
    logic [DATA_W-1:0] sig_rdata;
    logic              sig_err;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_we;
    logic              rf_re;
    logic [DATA_W-1:0] rf_rdata;

    modport slave (
        input  mac_req, mac_we, mac_addr, mac_wdata,
        output mac_ack, mac_rdata, mac_err,
        input  sig_req, sig_we, sig_addr, sig_wdata,
        output sig_ack, sig_rdata, sig_err,
        output rf_addr, rf_wdata, rf_we, rf_re,
        input  rf_rdata
    );

    modport master (
        output mac_req, mac_we, mac_addr, mac_wdata,
        input  mac_ack, mac_rdata, mac_err,
        output sig_req, sig_we, sig_addr, sig_wdata,
        input  sig_ack, sig_rdata, sig_err,
        input  rf_addr, rf_wdata, rf_we, rf_re,
        output rf_rdata
    );
endinterface

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: single-port access controller sharing a DEPTH x DATA_W register file between MAC and sig.
//   clk, reset : clock and synchronous active-high reset
//   bus        : regfile_arbiter_if.slave -- mac_*/sig_* request/ack handshakes and the rf_* file port
//   busy       : high whenever the FSM is not idle
//   err_cnt    : saturating count of out-of-range requests
//   Define REGARB_FIXED_PRIO_EN to give MAC fixed priority on ties instead of round-robin.
module regfile_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 100
) (
    input  logic                clk,
    input  logic                reset,
    regfile_arbiter_if.slave    bus,
    output logic                busy,
    output logic [7:0]          err_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_d;
    logic              gnt_sig, gnt_sig_d;
    logic              last_sig, last_sig_d;
    logic              l_we, l_we_d;
    logic [ADDR_W-1:0] l_addr, l_addr_d;
    logic [DATA_W-1:0] l_wdata, l_wdata_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              rf_we_q, rf_we_d;
    logic              rf_re_q, rf_re_d;
    logic              mac_ack_q, mac_ack_d;
    logic              sig_ack_q, sig_ack_d;
    logic              mac_err_q, mac_err_d;
    logic              sig_err_q, sig_err_d;
    logic [DATA_W-1:0] mac_rdata_q, mac_rdata_d;
    logic [DATA_W-1:0] sig_rdata_q, sig_rdata_d;
    logic [7:0]        err_cnt_d;
    logic              busy_d;
    logic              sig_win;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_err;
    logic              l_err;
    logic              fast;

    // Extra MSB so a DEPTH equal to 2**ADDR_W still compares correctly.
    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} >= (ADDR_W+1)'(DEPTH);
    endfunction

`ifdef REGARB_FIXED_PRIO_EN
    assign sig_win = bus.sig_req && !bus.mac_req;
`else
    // On a tie the requester that was not served last wins.
    assign sig_win = bus.sig_req && (!bus.mac_req || !last_sig);
`endif

    assign w_we    = sig_win ? bus.sig_we    : bus.mac_we;
    assign w_addr  = sig_win ? bus.sig_addr  : bus.mac_addr;
    assign w_wdata = sig_win ? bus.sig_wdata : bus.mac_wdata;
    assign w_err   = out_of_range(w_addr);
    assign l_err   = out_of_range(l_addr);
    // Writes and errors skip WAIT and answer straight from ISSUE.
    assign fast    = l_we || l_err;

    always_comb begin
        state_d     = state;
        gnt_sig_d   = gnt_sig;
        last_sig_d  = last_sig;
        l_we_d      = l_we;
        l_addr_d    = l_addr;
        l_wdata_d   = l_wdata;
        err_cnt_d   = err_cnt;
        rf_addr_d   = '0;
        rf_wdata_d  = '0;
        rf_we_d     = 1'b0;
        rf_re_d     = 1'b0;
        mac_ack_d   = 1'b0;
        sig_ack_d   = 1'b0;
        mac_err_d   = 1'b0;
        sig_err_d   = 1'b0;
        mac_rdata_d = '0;
        sig_rdata_d = '0;
        case (state)
            IDLE: begin
                if (bus.mac_req || bus.sig_req) begin
                    // Strobes are registered here so they are high exactly during ISSUE.
                    gnt_sig_d  = sig_win;
                    l_we_d     = w_we;
                    l_addr_d   = w_addr;
                    l_wdata_d  = w_wdata;
                    rf_we_d    = w_we && !w_err;
                    rf_re_d    = !w_we && !w_err;
                    rf_addr_d  = w_err ? '0 : w_addr;
                    rf_wdata_d = (w_we && !w_err) ? w_wdata : '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d   = fast ? RESP : WAIT;
                mac_ack_d = fast && !gnt_sig;
                sig_ack_d = fast && gnt_sig;
                mac_err_d = l_err && !gnt_sig;
                sig_err_d = l_err && gnt_sig;
            end
            WAIT: begin
                state_d     = RESP;
                mac_ack_d   = !gnt_sig;
                sig_ack_d   = gnt_sig;
                mac_rdata_d = gnt_sig ? '0 : bus.rf_rdata;
                sig_rdata_d = gnt_sig ? bus.rf_rdata : '0;
            end
            RESP: begin
                state_d    = IDLE;
                last_sig_d = gnt_sig;
                err_cnt_d  = (l_err && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            gnt_sig     <= 1'b0;
            last_sig    <= 1'b1;
            l_we        <= 1'b0;
            l_addr      <= '0;
            l_wdata     <= '0;
            rf_addr_q   <= '0;
            rf_wdata_q  <= '0;
            rf_we_q     <= 1'b0;
            rf_re_q     <= 1'b0;
            mac_ack_q   <= 1'b0;
            sig_ack_q   <= 1'b0;
            mac_err_q   <= 1'b0;
            sig_err_q   <= 1'b0;
            mac_rdata_q <= '0;
            sig_rdata_q <= '0;
            err_cnt     <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            gnt_sig     <= gnt_sig_d;
            last_sig    <= last_sig_d;
            l_we        <= l_we_d;
            l_addr      <= l_addr_d;
            l_wdata     <= l_wdata_d;
            rf_addr_q   <= rf_addr_d;
            rf_wdata_q  <= rf_wdata_d;
            rf_we_q     <= rf_we_d;
            rf_re_q     <= rf_re_d;
            mac_ack_q   <= mac_ack_d;
            sig_ack_q   <= sig_ack_d;
            mac_err_q   <= mac_err_d;
            sig_err_q   <= sig_err_d;
            mac_rdata_q <= mac_rdata_d;
            sig_rdata_q <= sig_rdata_d;
            err_cnt     <= err_cnt_d;
            busy        <= busy_d;
        end
    end

    assign bus.rf_addr   = rf_addr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_re     = rf_re_q;
    assign bus.mac_ack   = mac_ack_q;
    assign bus.sig_ack   = sig_ack_q;
    assign bus.mac_err   = mac_err_q;
    assign bus.sig_err   = sig_err_q;
    assign bus.mac_rdata = mac_rdata_q;
    assign bus.sig_rdata = sig_rdata_q;
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: randomized scoreboard bench for regfile_arbiter against a shadow-memory reference model.
module tb_regfile_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic [7:0] err_cnt;

    regfile_arbiter_if #(.DATA_W(16), .ADDR_W(7)) bus();

    regfile_arbiter dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [15:0] rd;
    } exp_t;

    exp_t        mac_q[$];
    exp_t        sig_q[$];
    int          gnt_log[$];
    logic [15:0] rf_mem[128];
    logic [15:0] model[100];
    int          total = 0;
    int          bad = 0;
    int          errs = 0;
    bit          mac_pend = 0;
    bit          sig_pend = 0;

    // Register file: read data appears the cycle after rf_re; junk otherwise.
    always @(posedge clk) begin
        if (bus.rf_we) rf_mem[bus.rf_addr] <= bus.rf_wdata;
        bus.rf_rdata <= bus.rf_re ? rf_mem[bus.rf_addr] : 16'($urandom);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain shadow memory; writes land in order of issue per requester.
    function automatic exp_t expect_of(input logic we, input logic [6:0] a, input logic [15:0] wd);
        exp_t e;
        e.err = a >= 7'd100;
        e.rd  = (!e.err && !we) ? model[a] : 16'h0;
        if (e.err) errs++;
        else if (we) model[a] = wd;
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever an ack is presented.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            chk("strobe_excl", int'(bus.rf_we && bus.rf_re), 0);
            chk("ack_excl", int'(bus.mac_ack && bus.sig_ack), 0);
            if (bus.mac_ack) begin
                gnt_log.push_back(0);
                if (mac_q.size() == 0) chk("mac_spurious_ack", 1, 0);
                else begin
                    e = mac_q.pop_front();
                    chk("mac_err", bus.mac_err, e.err);
                    chk("mac_rdata", bus.mac_rdata, e.rd);
                end
            end else if (mac_pend) begin
                chk("mac_wait_rdata", bus.mac_rdata, 0);
                chk("mac_wait_err", bus.mac_err, 0);
            end
            if (bus.sig_ack) begin
                gnt_log.push_back(1);
                if (sig_q.size() == 0) chk("sig_spurious_ack", 1, 0);
                else begin
                    e = sig_q.pop_front();
                    chk("sig_err", bus.sig_err, e.err);
                    chk("sig_rdata", bus.sig_rdata, e.rd);
                end
            end else if (sig_pend) begin
                chk("sig_wait_rdata", bus.sig_rdata, 0);
                chk("sig_wait_err", bus.sig_err, 0);
            end
        end
    end

    // lat != 0: start from an idle DUT and check strobes at +1 and ack latency.
    task automatic do_req(input int who, input logic we, input logic [6:0] addr,
                          input logic [15:0] wd, input int lat, input exp_t e);
        int n = 0;
        bit got = 0;
        if (lat != 0) begin
            @(posedge clk);
            #1;
        end
        if (who == 0) begin
            mac_q.push_back(e);
            mac_pend = 1;
            bus.mac_req = 1; bus.mac_we = we; bus.mac_addr = addr; bus.mac_wdata = wd;
        end else begin
            sig_q.push_back(e);
            sig_pend = 1;
            bus.sig_req = 1; bus.sig_we = we; bus.sig_addr = addr; bus.sig_wdata = wd;
        end
        while (!got && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (lat != 0 && n == 1) begin
                chk("issue_we", bus.rf_we, int'(we && !e.err));
                chk("issue_re", bus.rf_re, int'(!we && !e.err));
                if (!e.err) chk("issue_addr", bus.rf_addr, addr);
                if (we && !e.err) chk("issue_wdata", bus.rf_wdata, wd);
                if (who == 0) {bus.mac_we, bus.mac_addr, bus.mac_wdata} = 24'($urandom);
                else {bus.sig_we, bus.sig_addr, bus.sig_wdata} = 24'($urandom);
            end
            got = (who == 0) ? bus.mac_ack : bus.sig_ack;
        end
        chk(who == 0 ? "mac_ack_seen" : "sig_ack_seen", got, 1);
        if (lat != 0) chk("ack_latency", n, lat);
        if (who == 0) begin
            bus.mac_req = 0;
            mac_pend = 0;
        end else begin
            bus.sig_req = 0;
            sig_pend = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1;
        bus.mac_req = 0;
        bus.sig_req = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        errs = 0;
        mac_q.delete();
        sig_q.delete();
    endtask

    task automatic run_rand(input int who, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            logic        we = 1'($urandom);
            logic [6:0]  a  = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(100, 127))
                                                          : 7'(2 * $urandom_range(0, 49) + who);
            logic [15:0] wd = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            do_req(who, we, a, wd, 0, expect_of(we, a, wd));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   exp_order[8];
        exp_t e_m;
        exp_t e_s;
        bus.mac_req = 0; bus.mac_we = 0; bus.mac_addr = 0; bus.mac_wdata = 0;
        bus.sig_req = 0; bus.sig_we = 0; bus.sig_addr = 0; bus.sig_wdata = 0;
        for (int i = 0; i < 128; i++) rf_mem[i] = 16'h0;
        for (int i = 0; i < 100; i++) model[i] = 16'h0;
        do_reset();
        @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_acks", {bus.mac_ack, bus.sig_ack}, 0);
        chk("rst_strobes", {bus.rf_we, bus.rf_re}, 0);
        chk("rst_rdata", {bus.mac_rdata, bus.sig_rdata}, 0);

        do_req(0, 1, 7'd5, 16'hBEEF, 2, expect_of(1, 7'd5, 16'hBEEF));
        do_req(0, 0, 7'd5, 16'h0, 3, expect_of(0, 7'd5, 16'h0));

        do_req(1, 0, 7'd120, 16'h0, 2, expect_of(0, 7'd120, 16'h0));
        @(posedge clk);
        #1 chk("err_cnt_one", err_cnt, 1);

        // Read aborted by reset while the DUT waits for rf_rdata.
        @(posedge clk);
        #1 begin bus.mac_req = 1; bus.mac_we = 0; bus.mac_addr = 7'd7; end
        repeat (2) @(posedge clk);
        #1 chk("abort_busy_before", busy, 1);
        reset = 1;
        bus.mac_req = 0;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_strobes", {bus.rf_we, bus.rf_re}, 0);
        chk("abort_err_cnt", err_cnt, 0);
        chk("abort_ack", bus.mac_ack, 0);
        reset = 0;
        errs = 0;
        repeat (4) begin
            @(posedge clk);
            #1 chk("abort_no_ack", bus.mac_ack, 0);
        end

        do_reset();
        gnt_log.delete();
        fork
            for (int k = 0; k < 4; k++) do_req(0, 0, 7'(2 * k), 16'h0, 0, expect_of(0, 7'(2 * k), 16'h0));
            for (int k = 0; k < 4; k++) do_req(1, 0, 7'(2 * k + 1), 16'h0, 0, expect_of(0, 7'(2 * k + 1), 16'h0));
        join
        @(negedge clk);
        #1;
`ifdef REGARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        chk("alt_count", gnt_log.size(), 8);
        for (int k = 0; k < 8 && k < gnt_log.size(); k++) chk("alt_order", gnt_log[k], exp_order[k]);

        do_reset();
        gnt_log.delete();
        e_m = expect_of(1, 7'd99, 16'h1234);
        e_s = expect_of(0, 7'd99, 16'h0);
        fork
            do_req(0, 1, 7'd99, 16'h1234, 0, e_m);
            do_req(1, 0, 7'd99, 16'h0, 0, e_s);
        join
        @(negedge clk);
        #1;
        chk("collide_count", gnt_log.size(), 2);
        if (gnt_log.size() > 0) chk("collide_first", gnt_log[0], 0);

        fork
            run_rand(0, 40);
            run_rand(1, 40);
        join
        repeat (2) @(posedge clk);
        #1 chk("rand_err_cnt", err_cnt, errs > 255 ? 255 : errs);

        do_reset();
        for (int i = 0; i < 256; i++) begin
            logic       we = 1'($urandom);
            logic [6:0] a  = 7'($urandom_range(100, 127));
            do_req(i % 2, we, a, 16'($urandom), 2, expect_of(we, a, 16'h0));
            if (i == 254 || i == 255) begin
                @(posedge clk);
                #1 chk("sat_err_cnt", err_cnt, errs > 255 ? 255 : errs);
            end
        end

        repeat (2) @(posedge clk);
        #1;
        chk("mac_q_drained", mac_q.size(), 0);
        chk("sig_q_drained", sig_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Single-port access controller for the shared 100x16 register file.
- Two requesters share the file: the MAC datapath and the signal-processing block.
- Each request is latched, one read or write is sequenced onto the file port, and a one-cycle ack is returned with read data or an error flag.
- Replaces direct dual-master driving of the file, so MAC and sig can never collide.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 7, register address width
- DEPTH, 100, number of valid registers; addresses >= DEPTH are errors

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mac_req  in  1  MAC request; held high until mac_ack
- mac_we  in  1  1=write, 0=read; sampled with mac_req
- mac_addr  in  ADDR_W  MAC target register
- mac_wdata  in  DATA_W  MAC write data
- mac_ack  out  1  one-cycle completion pulse to MAC
- mac_rdata  out  DATA_W  read data, valid with mac_ack
- mac_err  out  1  out-of-range flag, valid with mac_ack
- sig_req, sig_we, sig_addr, sig_wdata, sig_ack, sig_rdata, sig_err: identical set for the sig requester
- rf_addr  out  ADDR_W  register file address
- rf_wdata  out  DATA_W  register file write data
- rf_we  out  1  register file write strobe
- rf_re  out  1  register file read strobe; rf_rdata is valid the cycle after
- rf_rdata  in  DATA_W  register file read data
- busy  out  1  high whenever state != IDLE
- err_cnt  out  8  saturating count of out-of-range requests

Behaviour:
- Reset, synchronous, active-high: clk and reset as named; reset is synchronous to clk and active-high.
  - state=IDLE, last_gnt=SIG (so MAC wins the first tie).
  - All outputs, latched request registers and err_cnt cleared to 0.
- All outputs are registered.
- FSM states:
  - IDLE: if any req is high, pick a winner and latch winner, we, addr and wdata; go to ISSUE. Otherwise stay.
  - ISSUE:
    - addr >= DEPTH: no rf strobe; go to RESP with err.
    - Write: rf_we=1 and rf_addr/rf_wdata driven from the latch for exactly this cycle; go to RESP.
    - Read: rf_re=1 for this cycle; go to WAIT.
  - WAIT: capture rf_rdata into the winner's rdata register; go to RESP.
  - RESP:
    - Winner's ack=1 for one cycle.
    - err=1 only on an error.
    - rdata=captured data on a read, 0 on a write or error.
    - last_gnt updated to the winner; err_cnt incremented on error, saturating at 255.
    - Next state IDLE.
- Arbitration in IDLE:
  - Exactly one req high: that requester wins.
  - Both high: the requester that is not last_gnt wins (round-robin).
- Latency, counted in cycles after the IDLE cycle where req is sampled:
  - Write ack: cycle +2.
  - Read ack: cycle +3.
  - Error ack: cycle +2.
  - Minimum issue spacing is 3 cycles for writes and 4 for reads.
- Handshake:
  - The requester deasserts req at the edge where it samples ack=1, so the following IDLE cycle does not re-grant.
  - A req held high after ack is treated as a new request.
  - Changing we/addr/wdata while waiting has no effect: the latched values are used.
  - Dropping req before ack does not cancel the transaction; ack still pulses.
- Only one of rf_we and rf_re is ever high; both are never high together.
- The loser's ack, err and rdata stay 0 while it waits.
- Reset mid-operation aborts the transaction: no ack is issued and rf strobes are 0 from the next cycle.

Optional Feature:
- Macro REGARB_FIXED_PRIO_EN.
  - Defined: MAC always wins when both requesters are active; last_gnt is still tracked but ignored.
  - Undefined: round-robin as described above.

Test Plan:
- MAC write addr 5 data 16'hBEEF, then MAC read addr 5 -> rf_we pulse at cycle +1 with rf_addr=5; read ack at cycle +3 with mac_rdata=16'hBEEF, mac_err=0.
- sig read addr 120 -> no rf_we/rf_re; sig_ack at cycle +2 with sig_err=1, sig_rdata=0; err_cnt=1.
- MAC and sig both request after reset, each held continuously -> grants alternate MAC, sig, MAC, sig; never two acks in the same cycle. With REGARB_FIXED_PRIO_EN defined, MAC is granted every time.
- MAC writes addr 99 = 16'h1234 while sig requests a read of addr 99 in the same cycle -> MAC is served first; sig receives 16'h1234.
- Reset asserted in WAIT during a read -> no ack; busy=0, rf strobes and err_cnt all 0 the next cycle.
- 256 consecutive out-of-range requests -> err_cnt saturates at 255.
